// File: rtl/cereal_arbiter.sv
// cereal_arbiter
// Shares one cereal serial transmitter among NREQ byte sources. The sources
// are served round-robin. One byte is latched per grant. The arbiter holds
// tx_start for START_HOLD cycles, then follows tx_busy until the frame is
// done, and only then grants the next source.
//
// Ports
//   sysclk    in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   enable    in   1        low: no new grants (an in-flight byte still finishes)
//   req       in   NREQ     per-requester request level
//   req_data  in   8*NREQ   byte for requester i on bits [8i+7:8i]
//   ack       out  NREQ     one-cycle pulse: requester i's byte was latched
//   tx_data   out  8        to cereal data; holds until the next grant
//   tx_start  out  1        to cereal start
//   tx_busy   in   1        from cereal status; high while a frame shifts
//   busy      out  1        high whenever the arbiter is not idle
//   grant_id  out  3        index of the last granted requester
//   err       out  1        one-cycle pulse when tx_busy never rose
//
// Handshake: a requester raises req[i] with req_data[i] and holds both stable
// until it sees ack[i] for one cycle. If req[i] is still high on the cycle
// after ack, that is a new request, and it queues behind the other pending
// requesters because the pointer has moved past i.

module cereal_arbiter #(
  parameter int NREQ       = 4,
  parameter int START_HOLD = 5702,
  parameter int TIMEOUT    = 65535
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic              err
);

  localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST_REQ  = 3'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [2:0]      ptr_q;
  logic [HW-1:0]   hold_cnt_q;
  logic [TW-1:0]   wait_cnt_q;
  logic            seen_busy_q;

  // Requests and bytes are widened to 8 slots so that a 3-bit index always
  // fits. Unused slots read as "no request" and 0x00.
  logic [7:0]      req_ext;
  logic [7:0]      byte_arr [8];
  logic [NREQ-1:0] ack_d;
  logic [2:0]      sel_d;
  logic            found_d;
  logic [3:0]      sum;
  logic [7:0]      sel_byte;

  for (genvar g = 0; g < 8; g++) begin : g_slot
    if (g < NREQ) begin : g_used
      assign req_ext[g]  = req[g];
      assign byte_arr[g] = req_data[8*g +: 8];
    end else begin : g_unused
      assign req_ext[g]  = 1'b0;
      assign byte_arr[g] = 8'h00;
    end
  end

  // Scan upward from ptr_q, wrapping mod NREQ, and take the first set bit.
  always_comb begin
    found_d = 1'b0;
    sel_d   = 3'd0;
    sum     = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + 4'(k);
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      if (!found_d && req_ext[sum[2:0]]) begin
        found_d = 1'b1;
        sel_d   = sum[2:0];
      end
    end
  end

  assign sel_byte = byte_arr[sel_d];

  for (genvar g = 0; g < NREQ; g++) begin : g_ack
    assign ack_d[g] = (sel_d == 3'(g));
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      seen_busy_q <= 1'b0;
      ack         <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 3'd0;
      err         <= 1'b0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable && found_d) begin
            ack      <= ack_d;
            tx_data  <= sel_byte;
            grant_id <= sel_d;
            ptr_q    <= (sel_d == LAST_REQ) ? 3'd0 : sel_d + 3'd1;
            // A zero byte is acked and dropped without starting a frame.
            if (sel_byte != 8'h00) begin
              state_q     <= START;
              tx_start    <= 1'b1;
              busy        <= 1'b1;
              hold_cnt_q  <= '0;
              wait_cnt_q  <= '0;
              seen_busy_q <= 1'b0;
            end
          end
        end
        START: begin
          if (tx_busy) seen_busy_q <= 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            tx_start   <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= WAIT_DONE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (seen_busy_q) begin
            if (!tx_busy) begin
              state_q     <= IDLE;
              busy        <= 1'b0;
              seen_busy_q <= 1'b0;
            end
          end else if (tx_busy) begin
            seen_busy_q <= 1'b1;
          end else if (wait_cnt_q == TO_LAST) begin
            // The counter hit TIMEOUT-1 on this edge, so TIMEOUT cycles
            // have passed in WAIT_DONE without tx_busy rising.
            err     <= 1'b1;
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (wait_cnt_q != {TW{1'b1}}) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          tx_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
